jt10_adpcm_rom_arb: RTL
=======================

Name: jt10_adpcm_rom_arb

Overview:
- Shares the single ADPCM sample-ROM read port between the ADPCM-B address counter and the six ADPCM-A channel fetchers.
- Grants one request at a time and runs the ROM chip-select/ready handshake.
- Returns the byte with a one-cycle acknowledge to the granted requester.
- Holds a one-entry byte cache so that back-to-back nibble reads of the same byte skip the ROM.

Parameters:
- TOUT, 255: cycles to wait for rom_ok before aborting a fetch.
- BFIRST, 1: 1 = ADPCM-B has fixed priority over ADPCM-A; 0 = ADPCM-B joins the round-robin as slot 6.

Ports:
- rst_n  in  1  asynchronous, active-low reset.
- clk  in  1  system clock.
- req_b  in  1  ADPCM-B read request; level, held until ack_b.
- addr_b  in  24  ADPCM-B byte address.
- ack_b  out  1  one-cycle pulse: data_b valid.
- data_b  out  8  ADPCM-B byte; holds its value until the next ack_b.
- req_a  in  6  per-channel ADPCM-A requests; level, held until the matching ack.
- addr_a  in  6x20 flattened  ADPCM-A byte addresses; channel n occupies bits [20n+19:20n].
- ack_a  out  6  one-hot one-cycle acknowledge.
- data_a  out  8  ADPCM-A byte; holds its value until the next ack_a.
- rom_addr  out  24  ROM byte address; ADPCM-A addresses are zero-extended.
- rom_cs  out  1  ROM read strobe; high for the whole transaction.
- rom_ok  in  1  ROM data valid; sampled only while rom_cs is high.
- rom_data  in  8  ROM byte.
- tout_err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset values: ack_b=0, ack_a=0, data_b=0, data_a=0, rom_addr=0, rom_cs=0, tout_err=0. Cache invalid. Round-robin pointer=0. FSM in IDLE.
- States: IDLE, CHK, FETCH, ACK.
- IDLE:
  - If any request is pending, pick a winner and latch its id and 24-bit address. Go to CHK.
  - Arbitration with BFIRST=1: req_b wins whenever it is set; otherwise ADPCM-A round-robin.
  - Arbitration with BFIRST=0: round-robin over 7 slots, A0..A5 then B.
  - Round-robin search starts at the pointer. After each grant, pointer = winner+1, wrapping 5→0 (6→0 when BFIRST=0).
- CHK:
  - Cache hit (cache valid and cached address == latched address): load the data register from the cache. Go to ACK. Total request-to-ack latency is 3 cycles.
  - Miss: drive rom_addr, assert rom_cs, clear the timeout counter. Go to FETCH.
- FETCH:
  - rom_cs stays high.
  - On rom_ok: capture rom_data into the cache; cache address = latched address, cache valid. Drop rom_cs. Go to ACK.
  - When the timeout counter reaches TOUT without rom_ok: return data 8'h00, set tout_err, invalidate the cache, drop rom_cs. Go to ACK.
- ACK:
  - Pulse the winner's ack for exactly one cycle and update its data output. Go to IDLE.
  - A requester must drop req on the cycle after ack. A req still high in IDLE is treated as a new request.
- Only one ack bit (ack_b or any ack_a) is ever high in a given cycle.
- A request arriving during a transaction waits; it is never dropped.
- Requests are not re-sampled after the grant. If a request deasserts mid-transaction, the fetch still completes and the ack is still issued.
- The cache is shared by all requesters. It is compared on the full 24-bit address, so an A and a B read of the same location both hit.
- rom_addr holds its last value while rom_cs is low.
- Asynchronous reset mid-fetch: rom_cs drops immediately, no ack is issued, and all state returns to the reset values.

Test Plan:
- Reset, then req_a[2]=1, addr=0x00123, rom_ok returning 0x5A two cycles after rom_cs -> rom_addr=0x000123, a single ack_a=6'b000100 pulse, data_a=0x5A.
- Same request repeated after it completes -> no rom_cs assertion, ack_a[2] 3 cycles after req, data_a=0x5A (cache hit).
- req_b and req_a[0] raised in the same cycle, BFIRST=1 -> B served first, then A0; rom_cs drops between the two transactions.
- req_a=6'b111111 held continuously, distinct addresses -> grant order 0,1,2,3,4,5,0; no channel is served twice before the others.
- rom_ok never asserted -> rom_cs high for TOUT cycles, then ack with data 0x00, tout_err=1, cache invalidated (next same-address read hits the ROM).
- rst_n pulsed low during FETCH -> rom_cs=0 asynchronously, no ack, tout_err=0; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/jt10_adpcm_rom_arb_if.sv
// Requester and ROM-side signals of the ADPCM sample-ROM arbiter.
// slave = arbiter view; master = the requesters plus the ROM model driving it.
interface jt10_adpcm_rom_arb_if;
    logic         req_b;
    logic [23:0]  addr_b;
    logic         ack_b;
    logic [7:0]   data_b;
    logic [5:0]   req_a;
    logic [119:0] addr_a;
    logic [5:0]   ack_a;
    logic [7:0]   data_a;
    logic [23:0]  rom_addr;
    logic         rom_cs;
    logic         rom_ok;
    logic [7:0]   rom_data;
    logic         tout_err;

    modport slave (
        input  req_b, addr_b, req_a, addr_a, rom_ok, rom_data,
        output ack_b, data_b, ack_a, data_a, rom_addr, rom_cs, tout_err
    );

    modport master (
        output req_b, addr_b, req_a, addr_a, rom_ok, rom_data,
        input  ack_b, data_b, ack_a, data_a, rom_addr, rom_cs, tout_err
    );
endinterface

// File: rtl/jt10_adpcm_rom_arb.sv
// Shares one ADPCM sample-ROM port among ADPCM-B and six ADPCM-A fetchers, with a 1-byte cache.
// Cache hit acks 3 cycles after req; misses wait on rom_ok up to TOUT cycles; requests queue as held levels.
module jt10_adpcm_rom_arb #(
    parameter int TOUT   = 255,
    parameter bit BFIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    jt10_adpcm_rom_arb_if.slave        bus
);
    localparam int NSLOT = BFIRST ? 6 : 7;
    localparam int TW    = $clog2(TOUT + 1);

    typedef enum logic [1:0] {IDLE, CHK, FETCH, ACK} state_t;

    state_t        state_q, state_d;
    logic [2:0]    id_q, id_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [23:0]   addr_q, addr_d;
    logic [23:0]   rom_addr_q, rom_addr_d;
    logic          rom_cs_q, rom_cs_d;
    logic          cache_vld_q, cache_vld_d;
    logic [23:0]   cache_addr_q, cache_addr_d;
    logic [7:0]    cache_dat_q, cache_dat_d;
    logic [7:0]    dat_q, dat_d;
    logic [7:0]    data_a_q, data_a_d;
    logic [7:0]    data_b_q, data_b_d;
    logic          ack_b_q, ack_b_d;
    logic [5:0]    ack_a_q, ack_a_d;
    logic          tout_q, tout_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic [6:0]    slot_req;
    logic          grant_vld;
    logic [2:0]    grant_id;
    logic [23:0]   grant_addr;
    logic [2:0]    ptr_nxt;
    logic [3:0]    idx;

    // Slots 0..5 are ADPCM-A channels, slot 6 is ADPCM-B.
    always_comb begin
        slot_req  = {bus.req_b, bus.req_a};
        grant_vld = 1'b0;
        grant_id  = 3'd0;
        idx       = 4'd0;
        if (BFIRST && bus.req_b) begin
            grant_vld = 1'b1;
            grant_id  = 3'd6;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                idx = {1'b0, ptr_q} + 4'(i);
                if (idx >= 4'(NSLOT)) idx = idx - 4'(NSLOT);
                if (!grant_vld && slot_req[idx[2:0]]) begin
                    grant_vld = 1'b1;
                    grant_id  = idx[2:0];
                end
            end
        end
    end

    always_comb begin
        grant_addr = bus.addr_b;
        for (int j = 0; j < 6; j++) begin
            if (grant_id == 3'(j)) grant_addr = {4'h0, bus.addr_a[20*j +: 20]};
        end
        ptr_nxt = grant_id + 3'd1;
        if (ptr_nxt == 3'(NSLOT)) ptr_nxt = 3'd0;
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        ptr_d        = ptr_q;
        addr_d       = addr_q;
        rom_addr_d   = rom_addr_q;
        rom_cs_d     = rom_cs_q;
        cache_vld_d  = cache_vld_q;
        cache_addr_d = cache_addr_q;
        cache_dat_d  = cache_dat_q;
        dat_d        = dat_q;
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        ack_b_d      = 1'b0;
        ack_a_d      = 6'd0;
        tout_d       = tout_q;
        tcnt_d       = tcnt_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    id_d    = grant_id;
                    addr_d  = grant_addr;
                    // With B on fixed priority it sits outside the rotation, so its grants leave the pointer alone.
                    if (!(BFIRST && grant_id == 3'd6)) ptr_d = ptr_nxt;
                    state_d = CHK;
                end
            end
            CHK: begin
                if (cache_vld_q && cache_addr_q == addr_q) begin
                    dat_d   = cache_dat_q;
                    state_d = ACK;
                end else begin
                    rom_addr_d = addr_q;
                    rom_cs_d   = 1'b1;
                    tcnt_d     = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (bus.rom_ok) begin
                    cache_vld_d  = 1'b1;
                    cache_addr_d = addr_q;
                    cache_dat_d  = bus.rom_data;
                    dat_d        = bus.rom_data;
                    rom_cs_d     = 1'b0;
                    state_d      = ACK;
                end else if (tcnt_q == TW'(TOUT - 1)) begin
                    dat_d       = 8'h00;
                    tout_d      = 1'b1;
                    cache_vld_d = 1'b0;
                    rom_cs_d    = 1'b0;
                    state_d     = ACK;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ACK: begin
                if (id_q == 3'd6) begin
                    ack_b_d  = 1'b1;
                    data_b_d = dat_q;
                end else begin
                    ack_a_d  = 6'd1 << id_q;
                    data_a_d = dat_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            id_q         <= 3'd0;
            ptr_q        <= 3'd0;
            addr_q       <= 24'd0;
            rom_addr_q   <= 24'd0;
            rom_cs_q     <= 1'b0;
            cache_vld_q  <= 1'b0;
            cache_addr_q <= 24'd0;
            cache_dat_q  <= 8'd0;
            dat_q        <= 8'd0;
            data_a_q     <= 8'd0;
            data_b_q     <= 8'd0;
            ack_b_q      <= 1'b0;
            ack_a_q      <= 6'd0;
            tout_q       <= 1'b0;
            tcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            ptr_q        <= ptr_d;
            addr_q       <= addr_d;
            rom_addr_q   <= rom_addr_d;
            rom_cs_q     <= rom_cs_d;
            cache_vld_q  <= cache_vld_d;
            cache_addr_q <= cache_addr_d;
            cache_dat_q  <= cache_dat_d;
            dat_q        <= dat_d;
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            ack_b_q      <= ack_b_d;
            ack_a_q      <= ack_a_d;
            tout_q       <= tout_d;
            tcnt_q       <= tcnt_d;
        end
    end

    assign bus.ack_b    = ack_b_q;
    assign bus.data_b   = data_b_q;
    assign bus.ack_a    = ack_a_q;
    assign bus.data_a   = data_a_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_cs   = rom_cs_q;
    assign bus.tout_err = tout_q;
endmodule
